// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory
// hold with a watchdog FSM. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode_ID,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        memread_EX,
  input  logic [4:0]  rd_EX,
  input  logic        branch_taken_EX,
  input  logic        dmem_req_MEM,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [1:0]  state,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] mem_wait_cnt
);

  // state    | meaning
  // RUN      | normal flow, no outstanding memory wait
  // MEM_WAIT | data access outstanding, counting hold cycles
  // TIMEOUT  | memory hung, core frozen until reset
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_TIMEOUT  = 2'b10
  } state_t;

  localparam logic [7:0] TMO     = MEM_TIMEOUT[7:0];
  localparam logic       TMO_ONE = (MEM_TIMEOUT == 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_inc;
  logic       uses_rs1, uses_rs2;
  logic       load_use;
  logic       hold;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode_ID)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0000011, 7'b0010011, 7'b1100111: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = memread_EX && (rd_EX != 5'd0) &&
                    ((uses_rs1 && (rd_EX == rs1_ID)) ||
                     (uses_rs2 && (rd_EX == rs2_ID)));

  assign hold = ((state_q == ST_RUN) && dmem_req_MEM && !dmem_ready) ||
                ((state_q == ST_MEM_WAIT) && !dmem_ready) ||
                (state_q == ST_TIMEOUT);

  assign wait_inc = wait_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_hold    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_req_MEM && !dmem_ready) begin
          wait_cnt_d = 8'd1;
          state_d    = TMO_ONE ? ST_TIMEOUT : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_inc == TMO) begin
          state_d = ST_TIMEOUT;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      ST_TIMEOUT: ;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    // Hold outranks everything: EX is frozen, so branch/load-use re-present later.
    if (hold) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (branch_taken_EX) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = (state_q == ST_TIMEOUT);

`ifdef HAZARD_PERF_CNT_EN
  logic lu_evt, flush_evt, wait_evt;

  assign lu_evt    = !hold && !branch_taken_EX && load_use;
  assign flush_evt = !hold && branch_taken_EX;
  assign wait_evt  = hold && (state_q != ST_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt <= 16'd0;
      flush_cnt    <= 16'd0;
      mem_wait_cnt <= 16'd0;
    end else begin
      if (lu_evt)    lu_stall_cnt <= lu_stall_cnt + 16'd1;
      if (flush_evt) flush_cnt    <= flush_cnt + 16'd1;
      if (wait_evt)  mem_wait_cnt <= mem_wait_cnt + 16'd1;
    end
  end
`else
  assign lu_stall_cnt = 16'd0;
  assign flush_cnt    = 16'd0;
  assign mem_wait_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios then random traffic, all
// checked against a cycle-level reference model of the hazard rules.
module tb_hazard_controller;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode_ID = 7'd0;
  logic [4:0]  rs1_ID = 5'd0, rs2_ID = 5'd0, rd_EX = 5'd0;
  logic        memread_EX = 1'b0, branch_taken_EX = 1'b0;
  logic        dmem_req_MEM = 1'b0, dmem_ready = 1'b0;
  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold, mem_timeout;
  logic [1:0]  state;
  logic [15:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;

  int total = 0;
  int bad = 0;

  // reference model: consecutive-hold count, fatal flag, perf tallies
  bit          m_fatal, m_pending;
  int          m_k;
  logic [15:0] m_lu, m_fl, m_mw;
  bit          c_hold, c_lu, c_br;

  logic [6:0] ops [9] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011,
                          7'b0010011, 7'b1100111, 7'b0110111, 7'b1101111, 7'b0001111};

  hazard_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_ID(opcode_ID), .rs1_ID(rs1_ID),
    .rs2_ID(rs2_ID), .memread_EX(memread_EX), .rd_EX(rd_EX),
    .branch_taken_EX(branch_taken_EX), .dmem_req_MEM(dmem_req_MEM),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble), .pipe_hold(pipe_hold),
    .mem_timeout(mem_timeout), .state(state), .lu_stall_cnt(lu_stall_cnt),
    .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fatal = 0; m_pending = 0; m_k = 0;
    m_lu = 0; m_fl = 0; m_mw = 0;
  endtask

  task automatic check(input string tag);
    bit u1, u2;
    logic [4:0] ev;
    logic [1:0] es;
    u1 = 0; u2 = 0;
    if (opcode_ID inside {7'b0110011, 7'b0100011, 7'b1100011}) begin u1 = 1; u2 = 1; end
    else if (opcode_ID inside {7'b0000011, 7'b0010011, 7'b1100111}) u1 = 1;
    c_lu   = memread_EX && rd_EX != 0 && ((u1 && rd_EX == rs1_ID) || (u2 && rd_EX == rs2_ID));
    c_br   = branch_taken_EX;
    c_hold = m_fatal || (m_pending ? !dmem_ready : (dmem_req_MEM && !dmem_ready));
    if (c_hold)    ev = 5'b00001;
    else if (c_br) ev = 5'b11110;
    else if (c_lu) ev = 5'b00010;
    else           ev = 5'b11000;
    es = m_fatal ? 2'b10 : (m_pending ? 2'b01 : 2'b00);
    chk({tag, ".ctl"}, {27'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold},
        {27'd0, ev});
    chk({tag, ".state"}, {30'd0, state}, {30'd0, es});
    chk({tag, ".tmo"}, {31'd0, mem_timeout}, {31'd0, m_fatal});
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".lu_cnt"}, {16'd0, lu_stall_cnt}, {16'd0, m_lu});
    chk({tag, ".fl_cnt"}, {16'd0, flush_cnt}, {16'd0, m_fl});
    chk({tag, ".mw_cnt"}, {16'd0, mem_wait_cnt}, {16'd0, m_mw});
`else
    chk({tag, ".lu_cnt"}, {16'd0, lu_stall_cnt}, 32'd0);
    chk({tag, ".fl_cnt"}, {16'd0, flush_cnt}, 32'd0);
    chk({tag, ".mw_cnt"}, {16'd0, mem_wait_cnt}, 32'd0);
`endif
  endtask

  task automatic model_advance();
    if (!c_hold && c_br) m_fl++;
    if (!c_hold && !c_br && c_lu) m_lu++;
    if (!m_fatal) begin
      if (c_hold) begin
        m_mw++;
        m_k++;
        if (m_k >= TMO) begin m_fatal = 1; m_pending = 0; end
        else m_pending = 1;
      end else begin
        m_k = 0; m_pending = 0;
      end
    end
  endtask

  task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic mr, input logic [4:0] rd, input logic br,
                      input logic rq, input logic rdy, input string tag);
    opcode_ID = op; rs1_ID = r1; rs2_ID = r2; memread_EX = mr; rd_EX = rd;
    branch_taken_EX = br; dmem_req_MEM = rq; dmem_ready = rdy;
    @(negedge clk);
    check(tag);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    opcode_ID = 7'd0; rs1_ID = 0; rs2_ID = 0; memread_EX = 0; rd_EX = 0;
    branch_taken_EX = 0; dmem_req_MEM = 0; dmem_ready = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // load-use: add x3,x1,x2 with load rd=x2 in EX, then normal
    step(7'b0110011, 5'd1, 5'd2, 1, 5'd2, 0, 0, 0, "lu_stall");
    chk("lu_pc_low", {31'd0, pc_write}, 32'd0);
    step(7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, "lu_after");
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_cnt_one", {16'd0, lu_stall_cnt}, 32'd1);
`else
    chk("lu_cnt_zero", {16'd0, lu_stall_cnt}, 32'd0);
`endif

    // no stall: lui, and load to x0
    step(7'b0110111, 5'd5, 5'd0, 1, 5'd5, 0, 0, 0, "lui_nostall");
    step(7'b0010011, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, "x0_nostall");
    step(7'b0100011, 5'd7, 5'd9, 1, 5'd9, 0, 0, 0, "store_rs2");

    // branch beats load-use
    step(7'b0110011, 5'd4, 5'd2, 1, 5'd4, 1, 0, 0, "br_lu");
    chk("br_flush", {31'd0, IF_ID_flush}, 32'd1);

    // three-cycle memory wait with a branch during the hold
    do_reset("rst_mw");
    step(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, "mw0");
    chk("mw_noflush", {31'd0, IF_ID_flush}, 32'd0);
    step(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, "mw1");
    step(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, "mw2");
    step(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, "mw_rdy");
    step(7'b0010011, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, "mw_done");
    chk("mw_run", {30'd0, state}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("mw_cnt3", {16'd0, mem_wait_cnt}, 32'd3);
`endif

    // zero-latency access
    step(7'b0000011, 5'd1, 5'd0, 0, 5'd0, 0, 1, 1, "mem_fast");

    // hung memory: TMO hold cycles then fatal, reset mid-TIMEOUT
    for (int i = 0; i < TMO; i++) step(7'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, "tmo_hold");
    for (int i = 0; i < 3; i++) step(7'd0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, "tmo_stuck");
    chk("tmo_state", {30'd0, state}, 32'd2);
    chk("tmo_flag", {31'd0, mem_timeout}, 32'd1);
    do_reset("tmo_reset");
    chk("tmo_rst_state", {30'd0, state}, 32'd0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ((m_fatal && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        do_reset("rnd_rst");
      else
        step(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
